// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: bundles the three producer handshakes (ALU, LSU, BRU), the
// registered common-data-bus broadcast and the conflict counter.
//
// Signal summary:
//   <src>_valid   producer offers a result       (src = alu, lsu, bru)
//   <src>_value   32-bit result value
//   <src>_rob_id  destination reorder-buffer entry
//   <src>_ready   arbiter accepts the offer this cycle
//   cdb_valid     broadcast valid (registered)
//   cdb_value     broadcast value (registered)
//   cdb_rob_id    broadcast reorder-buffer id (registered)
//   conflict_cnt  saturating count of cycles with two or more holders busy
//
// Modports:
//   master  producers / CDB consumers (drive offers, observe ready and CDB)
//   slave   the arbiter itself
interface cdb_arbiter_if #(
  parameter int ROB_SIZE_BIT = 5,
  parameter int CNT_BIT      = 16
);

  logic                    alu_valid;
  logic [31:0]             alu_value;
  logic [ROB_SIZE_BIT-1:0] alu_rob_id;
  logic                    alu_ready;

  logic                    lsu_valid;
  logic [31:0]             lsu_value;
  logic [ROB_SIZE_BIT-1:0] lsu_rob_id;
  logic                    lsu_ready;

  logic                    bru_valid;
  logic [31:0]             bru_value;
  logic [ROB_SIZE_BIT-1:0] bru_rob_id;
  logic                    bru_ready;

  logic                    cdb_valid;
  logic [31:0]             cdb_value;
  logic [ROB_SIZE_BIT-1:0] cdb_rob_id;
  logic [CNT_BIT-1:0]      conflict_cnt;

  modport master (
    output alu_valid, alu_value, alu_rob_id,
    output lsu_valid, lsu_value, lsu_rob_id,
    output bru_valid, bru_value, bru_rob_id,
    input  alu_ready, lsu_ready, bru_ready,
    input  cdb_valid, cdb_value, cdb_rob_id, conflict_cnt
  );

  modport slave (
    input  alu_valid, alu_value, alu_rob_id,
    input  lsu_valid, lsu_value, lsu_rob_id,
    input  bru_valid, bru_value, bru_rob_id,
    output alu_ready, lsu_ready, bru_ready,
    output cdb_valid, cdb_value, cdb_rob_id, conflict_cnt
  );

endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares the single common-data-bus write-back path between the
// ALU reservation station (source 0), the load/store buffer (source 1) and the
// branch unit (source 2). Each source owns a one-entry holding register; a
// round-robin arbiter picks one busy holder per cycle and drives a registered
// broadcast towards the reorder buffer and the wake-up logic.
//
// Ports:
//   clk_in     system clock, all state changes on its rising edge
//   rst_in     synchronous active-high reset, highest priority
//   rdy_in     global enable; when low every register holds
//   rob_clear  reorder-buffer flush; drops offers and empties all holders
//   bus        cdb_arbiter_if.slave: producer handshakes, CDB broadcast and
//              the saturating conflict counter
module cdb_arbiter #(
  parameter int ROB_SIZE_BIT = 5,
  parameter int CNT_BIT      = 16
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         rdy_in,
  input  logic         rob_clear,
  cdb_arbiter_if.slave bus
);

  localparam int NSRC = 3;

  logic [NSRC-1:0]         src_valid;
  logic [31:0]             src_value   [NSRC];
  logic [ROB_SIZE_BIT-1:0] src_rob_id  [NSRC];
  logic [NSRC-1:0]         src_ready;

  logic [NSRC-1:0]         hv;
  logic [31:0]             hold_value  [NSRC];
  logic [ROB_SIZE_BIT-1:0] hold_rob_id [NSRC];

  logic [1:0]              rr_ptr;
  logic [1:0]              scan_order  [NSRC];
  logic                    win_found;
  logic [1:0]              win_idx;
  logic [NSRC-1:0]         grant;

  logic                    enable;
  logic [1:0]              hv_count;

  logic                    cdb_valid_q;
  logic [31:0]             cdb_value_q;
  logic [ROB_SIZE_BIT-1:0] cdb_rob_id_q;
  logic [CNT_BIT-1:0]      conflict_q;

  // Gather the three producer ports into index-addressable arrays so the
  // holder and grant logic can be written once for all sources.
  always_comb begin
    src_valid     = {bus.bru_valid, bus.lsu_valid, bus.alu_valid};
    src_value[0]  = bus.alu_value;
    src_value[1]  = bus.lsu_value;
    src_value[2]  = bus.bru_value;
    src_rob_id[0] = bus.alu_rob_id;
    src_rob_id[1] = bus.lsu_rob_id;
    src_rob_id[2] = bus.bru_rob_id;
  end

  // The cycle does useful work only when enabled and not being flushed;
  // reset is folded in so ready stays low while rst_in is asserted.
  assign enable = rdy_in && !rob_clear && !rst_in;

  // Round-robin winner selection. It looks only at the registered holders,
  // never at the incoming valids, so a new offer cannot change this cycle's
  // grant and ready has no combinational path from valid.
  always_comb begin
    case (rr_ptr)
      2'd1: begin
        scan_order[0] = 2'd1;
        scan_order[1] = 2'd2;
        scan_order[2] = 2'd0;
      end
      2'd2: begin
        scan_order[0] = 2'd2;
        scan_order[1] = 2'd0;
        scan_order[2] = 2'd1;
      end
      default: begin
        scan_order[0] = 2'd0;
        scan_order[1] = 2'd1;
        scan_order[2] = 2'd2;
      end
    endcase
    win_found = 1'b0;
    win_idx   = 2'd0;
    for (int i = 0; i < NSRC; i++) begin
      if (!win_found && hv[scan_order[i]]) begin
        win_found = 1'b1;
        win_idx   = scan_order[i];
      end
    end
    grant = '0;
    for (int k = 0; k < NSRC; k++) begin
      grant[k] = win_found && (win_idx == 2'(k));
    end
  end

  // A holder can take a new result when it is empty or is being drained by
  // the grant this very cycle, which keeps an uncontested source streaming
  // at one result per cycle.
  assign src_ready = {NSRC{enable}} & (~hv | grant);

  assign hv_count = 2'(hv[0]) + 2'(hv[1]) + 2'(hv[2]);

  // Holding registers. An accept always wins over the drain of a granted
  // holder: the old content leaves on the CDB while the new one replaces it.
  // A flush empties every holder but leaves the stale data in place since
  // nothing reads it without the valid bit.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      hv <= '0;
      for (int k = 0; k < NSRC; k++) begin
        hold_value[k]  <= '0;
        hold_rob_id[k] <= '0;
      end
    end else if (rdy_in) begin
      if (rob_clear) begin
        hv <= '0;
      end else begin
        for (int k = 0; k < NSRC; k++) begin
          if (src_valid[k] && src_ready[k]) begin
            hv[k]          <= 1'b1;
            hold_value[k]  <= src_value[k];
            hold_rob_id[k] <= src_rob_id[k];
          end else if (grant[k]) begin
            hv[k] <= 1'b0;
          end
        end
      end
    end
  end

  // Registered broadcast and round-robin pointer. The pointer moves past the
  // winner so the winner becomes the lowest priority next cycle. Without a
  // winner the value and id keep their last contents and only valid drops.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cdb_valid_q  <= 1'b0;
      cdb_value_q  <= '0;
      cdb_rob_id_q <= '0;
      rr_ptr       <= 2'd0;
    end else if (rdy_in) begin
      if (rob_clear) begin
        cdb_valid_q <= 1'b0;
        rr_ptr      <= 2'd0;
      end else if (win_found) begin
        cdb_valid_q  <= 1'b1;
        cdb_value_q  <= hold_value[win_idx];
        cdb_rob_id_q <= hold_rob_id[win_idx];
        rr_ptr       <= (win_idx == 2'd2) ? 2'd0 : win_idx + 2'd1;
      end else begin
        cdb_valid_q <= 1'b0;
      end
    end
  end

  // Contention statistic: counts enabled cycles in which at least two
  // holders are waiting. It saturates instead of wrapping and deliberately
  // survives a flush so it reflects the whole run since reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      conflict_q <= '0;
    end else if (enable && (hv_count >= 2'd2) && (conflict_q != '1)) begin
      conflict_q <= conflict_q + CNT_BIT'(1);
    end
  end

  assign bus.alu_ready    = src_ready[0];
  assign bus.lsu_ready    = src_ready[1];
  assign bus.bru_ready    = src_ready[2];
  assign bus.cdb_valid    = cdb_valid_q;
  assign bus.cdb_value    = cdb_value_q;
  assign bus.cdb_rob_id   = cdb_rob_id_q;
  assign bus.conflict_cnt = conflict_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed bench for cdb_arbiter. Expected CDB broadcasts are
// queued in hand-derived grant order; a forked monitor pops and compares one
// entry for every broadcast produced by an enabled clock edge. Ready,
// counter and timing points are compared directly by the main sequence.
// A second instance with a 2-bit counter covers saturation.
module tb_cdb_arbiter;

  localparam int RB = 5;
  localparam int CB = 16;

  typedef struct packed {
    logic [31:0]   value;
    logic [RB-1:0] id;
  } exp_t;

  logic clk_in    = 1'b0;
  logic rst_in    = 1'b1;
  logic rdy_in    = 1'b1;
  logic rob_clear = 1'b0;
  logic sat_clear = 1'b0;

  int   checks = 0;
  int   errors = 0;
  int   seen   = 0;
  exp_t exp_q[$];

  cdb_arbiter_if #(.ROB_SIZE_BIT(RB), .CNT_BIT(CB)) bus ();
  cdb_arbiter_if #(.ROB_SIZE_BIT(RB), .CNT_BIT(2))  sat_bus ();

  cdb_arbiter #(.ROB_SIZE_BIT(RB), .CNT_BIT(CB)) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .rdy_in    (rdy_in),
    .rob_clear (rob_clear),
    .bus       (bus.slave)
  );

  cdb_arbiter #(.ROB_SIZE_BIT(RB), .CNT_BIT(2)) dut_sat (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .rdy_in    (rdy_in),
    .rob_clear (sat_clear),
    .bus       (sat_bus.slave)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [31:0] vval(input int src, input logic [RB-1:0] id);
    return 32'hA000_0000 + (32'(src) << 28) + 32'(id);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic pushExp(input int src, input logic [RB-1:0] id);
    exp_t e;
    e.value = vval(src, id);
    e.id    = id;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic monitorLoop();
    logic en;
    exp_t e;
    forever begin
      @(posedge clk_in);
      en = rdy_in && !rob_clear && !rst_in;
      @(negedge clk_in);
      if (en && bus.cdb_valid) begin
        seen++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL cdb_unexpected: got id %0d value 0x%08h, expected no broadcast",
                   bus.cdb_rob_id, bus.cdb_value);
        end else begin
          e = exp_q.pop_front();
          checkOutput("cdb_value", bus.cdb_value, e.value);
          checkOutput("cdb_rob_id", 32'(bus.cdb_rob_id), 32'(e.id));
        end
      end
    end
  endtask

  // Offers na/nl/nb results from ALU/LSU/BRU with consecutive ids, moving to
  // the next item of a source only after its handshake. Returns the number of
  // cycles until every item was accepted; valids are dropped afterwards.
  task automatic applyStimulus(input int na, input int nl, input int nb,
                               input logic [RB-1:0] ida, input logic [RB-1:0] idl,
                               input logic [RB-1:0] idb, output int cycles);
    int  sa, sl, sb;
    logic acc_a, acc_l, acc_b;
    sa = 0; sl = 0; sb = 0;
    cycles = 0;
    while ((sa < na || sl < nl || sb < nb) && cycles < 40) begin
      bus.alu_valid  = (sa < na);
      bus.alu_rob_id = ida + RB'(sa);
      bus.alu_value  = vval(0, ida + RB'(sa));
      bus.lsu_valid  = (sl < nl);
      bus.lsu_rob_id = idl + RB'(sl);
      bus.lsu_value  = vval(1, idl + RB'(sl));
      bus.bru_valid  = (sb < nb);
      bus.bru_rob_id = idb + RB'(sb);
      bus.bru_value  = vval(2, idb + RB'(sb));
      #1;
      acc_a = bus.alu_valid && bus.alu_ready;
      acc_l = bus.lsu_valid && bus.lsu_ready;
      acc_b = bus.bru_valid && bus.bru_ready;
      tick();
      if (acc_a) sa++;
      if (acc_l) sl++;
      if (acc_b) sb++;
      cycles++;
    end
    bus.alu_valid = 1'b0;
    bus.lsu_valid = 1'b0;
    bus.bru_valid = 1'b0;
    if (sa < na || sl < nl || sb < nb) begin
      checks++;
      errors++;
      $display("FAIL stim_timeout: accepted %0d/%0d/%0d, required %0d/%0d/%0d",
               sa, sl, sb, na, nl, nb);
    end
  endtask

  initial begin
    int cyc;
    int seen0;

    bus.alu_valid = 1'b0; bus.alu_value = '0; bus.alu_rob_id = '0;
    bus.lsu_valid = 1'b0; bus.lsu_value = '0; bus.lsu_rob_id = '0;
    bus.bru_valid = 1'b0; bus.bru_value = '0; bus.bru_rob_id = '0;
    sat_bus.alu_valid = 1'b0; sat_bus.alu_value = '0; sat_bus.alu_rob_id = '0;
    sat_bus.lsu_valid = 1'b0; sat_bus.lsu_value = '0; sat_bus.lsu_rob_id = '0;
    sat_bus.bru_valid = 1'b0; sat_bus.bru_value = '0; sat_bus.bru_rob_id = '0;

    fork
      monitorLoop();
    join_none

    $display("[TB] reset state");
    bus.alu_valid = 1'b1;
    bus.lsu_valid = 1'b1;
    bus.bru_valid = 1'b1;
    #1;
    checkOutput("rst_alu_ready", 32'(bus.alu_ready), 32'd0);
    checkOutput("rst_lsu_ready", 32'(bus.lsu_ready), 32'd0);
    checkOutput("rst_bru_ready", 32'(bus.bru_ready), 32'd0);
    tick();
    tick();
    checkOutput("rst_cdb_valid", 32'(bus.cdb_valid), 32'd0);
    checkOutput("rst_cdb_value", bus.cdb_value, 32'd0);
    checkOutput("rst_cdb_rob_id", 32'(bus.cdb_rob_id), 32'd0);
    checkOutput("rst_conflict", 32'(bus.conflict_cnt), 32'd0);
    bus.alu_valid = 1'b0;
    bus.lsu_valid = 1'b0;
    bus.bru_valid = 1'b0;
    rst_in = 1'b0;

    $display("[TB] single source");
    begin
      exp_t e;
      e.value = 32'h1234_5678;
      e.id    = 5'd3;
      exp_q.push_back(e);
    end
    bus.alu_valid  = 1'b1;
    bus.alu_value  = 32'h1234_5678;
    bus.alu_rob_id = 5'd3;
    #1;
    checkOutput("single_alu_ready", 32'(bus.alu_ready), 32'd1);
    tick();
    bus.alu_valid = 1'b0;
    checkOutput("single_cdb_valid_e1", 32'(bus.cdb_valid), 32'd0);
    tick();
    checkOutput("single_cdb_valid_e2", 32'(bus.cdb_valid), 32'd1);
    checkOutput("single_cdb_value", bus.cdb_value, 32'h1234_5678);
    checkOutput("single_cdb_rob_id", 32'(bus.cdb_rob_id), 32'd3);
    tick();
    checkOutput("single_cdb_valid_e3", 32'(bus.cdb_valid), 32'd0);

    $display("[TB] three-way contention");
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    pushExp(0, 5'd1);
    pushExp(1, 5'd2);
    pushExp(2, 5'd3);
    applyStimulus(1, 1, 1, 5'd1, 5'd2, 5'd3, cyc);
    checkOutput("cont_cycles", 32'(cyc), 32'd1);
    checkOutput("cont_alu_ready_g", 32'(bus.alu_ready), 32'd1);
    checkOutput("cont_lsu_ready_w", 32'(bus.lsu_ready), 32'd0);
    checkOutput("cont_bru_ready_w", 32'(bus.bru_ready), 32'd0);
    tick();
    checkOutput("cont_lsu_ready_g", 32'(bus.lsu_ready), 32'd1);
    checkOutput("cont_bru_ready_w2", 32'(bus.bru_ready), 32'd0);
    tick();
    tick();
    checkOutput("cont_conflict", 32'(bus.conflict_cnt), 32'd2);
    tick();
    checkOutput("cont_cdb_idle", 32'(bus.cdb_valid), 32'd0);

    $display("[TB] fairness ALU vs BRU");
    pushExp(0, 5'd8);
    pushExp(2, 5'd16);
    pushExp(0, 5'd9);
    pushExp(2, 5'd17);
    pushExp(0, 5'd10);
    pushExp(2, 5'd18);
    applyStimulus(3, 0, 3, 5'd8, 5'd0, 5'd16, cyc);
    checkOutput("fair_cycles", 32'(cyc), 32'd5);
    tick();
    tick();
    tick();
    checkOutput("fair_conflict", 32'(bus.conflict_cnt), 32'd7);
    checkOutput("fair_cdb_idle", 32'(bus.cdb_valid), 32'd0);

    $display("[TB] streaming");
    for (int i = 0; i < 8; i++) pushExp(0, RB'(i));
    seen0 = seen;
    applyStimulus(8, 0, 0, 5'd0, 5'd0, 5'd0, cyc);
    checkOutput("stream_cycles", 32'(cyc), 32'd8);
    checkOutput("stream_mid_valid", 32'(bus.cdb_valid), 32'd1);
    checkOutput("stream_mid_id", 32'(bus.cdb_rob_id), 32'd6);
    tick();
    checkOutput("stream_last_id", 32'(bus.cdb_rob_id), 32'd7);
    tick();
    checkOutput("stream_end_valid", 32'(bus.cdb_valid), 32'd0);
    checkOutput("stream_count", 32'(seen - seen0), 32'd8);
    checkOutput("stream_conflict", 32'(bus.conflict_cnt), 32'd7);

    $display("[TB] flush");
    applyStimulus(0, 1, 1, 5'd0, 5'd4, 5'd5, cyc);
    rob_clear      = 1'b1;
    bus.alu_valid  = 1'b1;
    bus.alu_rob_id = 5'd30;
    bus.alu_value  = vval(0, 5'd30);
    #1;
    checkOutput("flush_alu_ready", 32'(bus.alu_ready), 32'd0);
    checkOutput("flush_lsu_ready", 32'(bus.lsu_ready), 32'd0);
    checkOutput("flush_bru_ready", 32'(bus.bru_ready), 32'd0);
    tick();
    rob_clear     = 1'b0;
    bus.alu_valid = 1'b0;
    checkOutput("flush_cdb_valid", 32'(bus.cdb_valid), 32'd0);
    checkOutput("flush_conflict", 32'(bus.conflict_cnt), 32'd7);
    tick();
    checkOutput("flush_holders_empty", 32'(bus.cdb_valid), 32'd0);
    pushExp(0, 5'd9);
    pushExp(1, 5'd10);
    applyStimulus(1, 1, 0, 5'd9, 5'd10, 5'd0, cyc);
    checkOutput("flush_after_e1", 32'(bus.cdb_valid), 32'd0);
    tick();
    checkOutput("flush_after_e2_valid", 32'(bus.cdb_valid), 32'd1);
    checkOutput("flush_after_e2_id", 32'(bus.cdb_rob_id), 32'd9);
    tick();
    checkOutput("flush_after_lsu_id", 32'(bus.cdb_rob_id), 32'd10);
    checkOutput("flush_after_conflict", 32'(bus.conflict_cnt), 32'd8);

    $display("[TB] stall");
    pushExp(2, 5'd14);
    pushExp(0, 5'd12);
    applyStimulus(1, 0, 1, 5'd12, 5'd0, 5'd14, cyc);
    tick();
    checkOutput("stall_pre_id", 32'(bus.cdb_rob_id), 32'd14);
    rdy_in         = 1'b0;
    bus.lsu_valid  = 1'b1;
    bus.lsu_rob_id = 5'd20;
    bus.lsu_value  = vval(1, 5'd20);
    #1;
    checkOutput("stall_alu_ready", 32'(bus.alu_ready), 32'd0);
    checkOutput("stall_lsu_ready", 32'(bus.lsu_ready), 32'd0);
    checkOutput("stall_bru_ready", 32'(bus.bru_ready), 32'd0);
    tick();
    tick();
    tick();
    checkOutput("stall_cdb_valid", 32'(bus.cdb_valid), 32'd1);
    checkOutput("stall_cdb_id", 32'(bus.cdb_rob_id), 32'd14);
    checkOutput("stall_cdb_value", bus.cdb_value, vval(2, 5'd14));
    checkOutput("stall_conflict", 32'(bus.conflict_cnt), 32'd9);
    rdy_in        = 1'b1;
    bus.lsu_valid = 1'b0;
    #1;
    checkOutput("resume_alu_ready", 32'(bus.alu_ready), 32'd1);
    tick();
    checkOutput("resume_cdb_id", 32'(bus.cdb_rob_id), 32'd12);
    tick();
    checkOutput("resume_cdb_idle", 32'(bus.cdb_valid), 32'd0);

    $display("[TB] reset mid-operation");
    applyStimulus(1, 0, 0, 5'd25, 5'd0, 5'd0, cyc);
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    tick();
    checkOutput("midrst_cdb_valid", 32'(bus.cdb_valid), 32'd0);
    checkOutput("midrst_conflict", 32'(bus.conflict_cnt), 32'd0);

    $display("[TB] counter saturation");
    sat_bus.alu_valid  = 1'b1;
    sat_bus.alu_value  = 32'h0000_0001;
    sat_bus.alu_rob_id = 5'd1;
    sat_bus.lsu_valid  = 1'b1;
    sat_bus.lsu_value  = 32'h0000_0002;
    sat_bus.lsu_rob_id = 5'd2;
    tick();
    tick();
    tick();
    checkOutput("sat_cnt_2", 32'(sat_bus.conflict_cnt), 32'd2);
    tick();
    tick();
    tick();
    checkOutput("sat_cnt_max", 32'(sat_bus.conflict_cnt), 32'd3);
    sat_bus.alu_valid = 1'b0;
    sat_bus.lsu_valid = 1'b0;

    tick();
    checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
